// File: rtl/bram_stream_reader.sv
// Streams the inclusive address range [start_address, end_address] out of a
// one-cycle-latency single-port bram as a valid/ready word stream.
//
// Output handshake: a word moves downstream on every rising clock edge where
// out_valid and out_ready are both high. While out_valid is high and out_ready
// is low, out_data and out_last hold. out_valid never depends on out_ready.
module bram_stream_reader #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] start_address,
    input  logic [RAM_ADDR_BITS-1:0] end_address,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state;
    logic [RAM_ADDR_BITS-1:0] remaining;
    logic                     pending;
    logic                     pending_last;
    logic [1:0]               count;
    logic [RAM_WIDTH-1:0]     slot1_data;
    logic                     slot1_last;

    logic                     pop;
    logic                     push;
    logic                     final_issue;
    logic [2:0]               occupancy;

    assign pop          = out_valid & out_ready;
    assign push         = pending;
    assign write_enable = 1'b0;
    assign busy         = (state != IDLE);
    assign out_valid    = (count != 2'd0);
    assign done         = (state == DRAIN) && pop && out_last;

    // Words already held or in flight, less the one leaving this cycle; a new
    // read is issued only if its data is guaranteed a free buffer slot.
    assign occupancy   = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    assign ram_enable  = (state == READ) && (occupancy < 3'd2);
    assign final_issue = ram_enable && (remaining == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            address      <= '0;
            remaining    <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            count        <= 2'd0;
            out_data     <= '0;
            out_last     <= 1'b0;
            slot1_data   <= '0;
            slot1_last   <= 1'b0;
        end else begin
            pending      <= ram_enable;
            pending_last <= final_issue;

            case (state)
                IDLE: begin
                    if (start) begin
                        address   <= start_address;
                        remaining <= end_address - start_address;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (ram_enable) begin
                        address   <= address + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == '0) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // out_data/out_last form the head slot; slot1 holds the second word.
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_data <= ram_data;
                        out_last <= pending_last;
                    end else begin
                        slot1_data <= ram_data;
                        slot1_last <= pending_last;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_data <= slot1_data;
                        out_last <= slot1_last;
                    end else begin
                        out_last <= 1'b0;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_data <= ram_data;
                        out_last <= pending_last;
                    end else begin
                        out_data   <= slot1_data;
                        out_last   <= slot1_last;
                        slot1_data <= ram_data;
                        slot1_last <= pending_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: attaches a behavioural one-cycle-latency RAM
// and checks every cycle against a transfer-level model of the stream.
module tb_bram_stream_reader;

    localparam int W     = 32;
    localparam int AB    = 9;
    localparam int DEPTH = 512;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AB-1:0] start_address;
    logic [AB-1:0] end_address;
    logic          busy;
    logic          done;
    logic          ram_enable;
    logic          write_enable;
    logic [AB-1:0] address;
    logic [W-1:0]  ram_data = '0;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    logic [W-1:0]  mem [DEPTH];

    int total = 0;
    int bad   = 0;

    // model state
    bit            active = 0;
    bit            was_active;
    bit            prev_issue = 0;
    bit            exp_valid, exp_pop, exp_en, exp_done;
    int            base = 0, len = 0, issued = 0, popped = 0;
    int            occ, buffered;
    int            t = 0;
    int            xfers = 0;
    int            first_valid = -1, done_cyc = -1, en_count = 0;
    int            ready_mode = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];

    always #5 clock = ~clock;

    bram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .start_address (start_address),
        .end_address   (end_address),
        .busy          (busy),
        .done          (done),
        .ram_enable    (ram_enable),
        .write_enable  (write_enable),
        .address       (address),
        .ram_data      (ram_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready)
    );

    // one-cycle registered read RAM
    always @(posedge clock) begin
        if (ram_enable) ram_data <= mem[address];
    end

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
        end
    endtask

    // out_ready driver: always ready, or random with a stall window
    always @(posedge clock) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (active && t >= 5 && t < 15) out_ready = 1'b0;
        else out_ready = ($urandom_range(0, 1) == 1);
    end

    // transfer-level model and per-cycle compare
    always @(negedge clock) begin
        if (reset) begin
            active     = 0;
            issued     = 0;
            popped     = 0;
            prev_issue = 0;
            exp_q.delete();
        end else begin
            was_active = active;
            if (active) t++;
            occ       = issued - popped;
            buffered  = occ - (prev_issue ? 1 : 0);
            exp_valid = active && (buffered > 0);
            exp_pop   = exp_valid && out_ready;
            exp_en    = active && (issued < len) && ((occ - (exp_pop ? 1 : 0)) < 2);
            exp_done  = exp_pop && (popped == len - 1);

            chk("busy", busy, active);
            chk("out_valid", out_valid, exp_valid);
            chk("ram_enable", ram_enable, exp_en);
            chk("write_enable", write_enable, 1'b0);
            chk("done", done, exp_done);
            if (exp_en) chk("address", address, (base + issued) % DEPTH);
            if (exp_valid) begin
                chk("out_data", out_data, exp_q[0]);
                chk("out_last", out_last, popped == len - 1);
            end

            if (active) begin
                if (out_valid && first_valid < 0) first_valid = t;
                if (done) done_cyc = t;
                if (ram_enable) en_count++;
            end

            prev_issue = exp_en;
            if (exp_en) issued++;
            if (exp_pop) begin
                got_q.push_back(out_data);
                void'(exp_q.pop_front());
                popped++;
            end
            if (exp_done) begin
                active = 0;
                xfers++;
            end

            if (!was_active && start) begin
                base        = int'(start_address);
                len         = ((int'(end_address) - int'(start_address)) & (DEPTH - 1)) + 1;
                issued      = 0;
                popped      = 0;
                prev_issue  = 0;
                t           = 0;
                first_valid = -1;
                done_cyc    = -1;
                en_count    = 0;
                exp_q.delete();
                got_q.delete();
                for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
                active = 1;
            end
        end
    end

    task automatic do_start(input int sa, input int ea);
        @(posedge clock);
        #1;
        start         = 1'b1;
        start_address = AB'(sa);
        end_address   = AB'(ea);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int  n0;
        bit  ok;
        n0 = xfers;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            #1;
            if (xfers > n0) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: transfer did not complete within %0d cycles", name, budget);
        end
    endtask

    task automatic check_words(input string name, input int first, input int n);
        chk({name, " word count"}, got_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < got_q.size()) chk({name, " word"}, got_q[k], (first + k) % DEPTH);
        end
    endtask

    task automatic check_reset_values(input string name);
        chk({name, " busy"}, busy, 1'b0);
        chk({name, " done"}, done, 1'b0);
        chk({name, " ram_enable"}, ram_enable, 1'b0);
        chk({name, " write_enable"}, write_enable, 1'b0);
        chk({name, " address"}, address, 0);
        chk({name, " out_valid"}, out_valid, 1'b0);
        chk({name, " out_data"}, out_data, 0);
        chk({name, " out_last"}, out_last, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
        reset         = 1'b1;
        start         = 1'b0;
        start_address = '0;
        end_address   = '0;
        out_ready     = 1'b1;
        ready_mode    = 0;
        #23;
        check_reset_values("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // basic read 4..7
        do_start(4, 7);
        wait_done("basic", 50);
        check_words("basic", 4, 4);
        chk("basic first valid cycle", first_valid, 3);
        chk("basic done cycle", done_cyc, 6);

        // single word
        do_start(10, 10);
        wait_done("single", 50);
        check_words("single", 10, 1);
        chk("single enable cycles", en_count, 1);
        chk("single done cycle", done_cyc, 3);

        // wrap through address 0
        do_start(510, 1);
        wait_done("wrap", 50);
        check_words("wrap", 510, 4);
        chk("wrap done cycle", done_cyc, 6);

        // backpressure: random ready plus a 10-cycle stall
        ready_mode = 1;
        do_start(0, 15);
        wait_done("backpressure", 400);
        check_words("backpressure", 0, 16);
        ready_mode = 0;

        // ignored start, then reset after 5 words
        do_start(100, 130);
        repeat (2) @(posedge clock);
        do_start(300, 301);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            #1;
            if (popped >= 5) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ignored start: 5 words not seen within 100 cycles");
        end
        check_words("ignored start", 100, 5);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("mid reset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        do_start(20, 21);
        wait_done("after reset", 50);
        check_words("after reset", 20, 2);
        chk("after reset done cycle", done_cyc, 4);

        // full memory
        do_start(0, 511);
        wait_done("full", 700);
        check_words("full", 0, 512);
        chk("full done cycle", done_cyc, 514);
        chk("full enable cycles", en_count, 512);

        repeat (3) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
